afe_spi_receiver: RTL and testbench

AFE_SPI_RECEIVER -- requirements
Module: afe_spi_receiver

---
 rtl/afe_spi_receiver.sv | 120 ++++++++++++
 tb/tb_afe_spi_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/afe_spi_receiver.sv
// Receives AFE SPI frames on sysClk. SCLK, SDI and LE are oversampled and synchronized.
// LE rising latches the frame; a bad bit count raises an error strobe and bumps a saturating counter.
`timescale 1ns/1ps
module afe_spi_receiver #(
  parameter int FRAME_BITS     = 8,
  parameter int ERRCOUNT_WIDTH = 16
) (
  input  logic                      sysClk,
  input  logic                      sysReset,
  input  logic                      spiClk,
  input  logic                      spiSdi,
  input  logic                      spiLe,
  input  logic                      errClear,
  output logic [FRAME_BITS-1:0]     frameData,
  output logic                      frameValid,
  output logic                      frameError,
  output logic [ERRCOUNT_WIDTH-1:0] errCount,
  output logic                      busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_nxt;

  logic sclk_meta, sclk_s, sclk_h;
  logic sdi_meta, sdi_s, sdi_h;
  logic le_meta, le_s, le_h;
  logic sclk_rise, le_rise, le_fall;
  logic le_fall_pend;
  logic err_inc;

  logic [FRAME_BITS-1:0] shift_q;
  logic [CW-1:0]         bit_cnt;

  // Two synchronizer flops plus one history flop per input
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      sclk_meta <= 1'b0; sclk_s <= 1'b0; sclk_h <= 1'b0;
      sdi_meta  <= 1'b0; sdi_s  <= 1'b0; sdi_h  <= 1'b0;
      le_meta   <= 1'b0; le_s   <= 1'b0; le_h   <= 1'b0;
    end else begin
      sclk_meta <= spiClk; sclk_s <= sclk_meta; sclk_h <= sclk_s;
      sdi_meta  <= spiSdi; sdi_s  <= sdi_meta;  sdi_h  <= sdi_s;
      le_meta   <= spiLe;  le_s   <= le_meta;   le_h   <= le_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_h;
  assign le_rise   = le_s & ~le_h;
  assign le_fall   = ~le_s & le_h;

  always_ff @(posedge sysClk) begin
    if (sysReset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (le_fall || le_fall_pend) state_nxt = SHIFT;
      SHIFT:   if (le_rise) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign err_inc = (state == LATCH) && (bit_cnt != CNT_FULL);

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      frameData    <= '0;
      frameValid   <= 1'b0;
      frameError   <= 1'b0;
      le_fall_pend <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frameValid   <= 1'b0;
      frameError   <= 1'b0;
      busy         <= (state_nxt == SHIFT);
      // An LE fall during LATCH would otherwise be lost; replay it in IDLE
      le_fall_pend <= (state == LATCH) && le_fall;
      case (state)
        IDLE: begin
          if (state_nxt == SHIFT) begin
            shift_q <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // sdi_h is one cycle older than the detected edge, still inside the setup window
          if (sclk_rise && !le_rise) begin
            shift_q <= (shift_q << 1) | FRAME_BITS'(sdi_h);
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (bit_cnt == CNT_FULL) begin
            frameData  <= shift_q;
            frameValid <= 1'b1;
          end else begin
            frameError <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset)                    errCount <= '0;
    else if (errClear)               errCount <= err_inc ? ERRCOUNT_WIDTH'(1) : '0;
    else if (err_inc && !(&errCount)) errCount <= errCount + 1'b1;
  end

endmodule

// File: tb/tb_afe_spi_receiver.sv
// Directed bench for afe_spi_receiver: a default instance and a 2-bit error-counter instance share stimulus.
`timescale 1ns/1ps
module tb_afe_spi_receiver;
  logic sysClk = 1'b0;
  logic sysReset, spiClk, spiSdi, spiLe, errClear;
  logic [7:0]  frameData, frameData2;
  logic        frameValid, frameError, busy;
  logic        frameValid2, frameError2, busy2;
  logic [15:0] errCount;
  logic [1:0]  errCount2;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0, ecnt = 0, vcnt2 = 0, ecnt2 = 0;
  logic [7:0] cap [8];

  always #5 sysClk = ~sysClk;

  afe_spi_receiver #(.FRAME_BITS(8), .ERRCOUNT_WIDTH(16)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .spiClk(spiClk), .spiSdi(spiSdi), .spiLe(spiLe),
    .errClear(errClear), .frameData(frameData), .frameValid(frameValid),
    .frameError(frameError), .errCount(errCount), .busy(busy));

  afe_spi_receiver #(.FRAME_BITS(8), .ERRCOUNT_WIDTH(2)) dut2 (
    .sysClk(sysClk), .sysReset(sysReset), .spiClk(spiClk), .spiSdi(spiSdi), .spiLe(spiLe),
    .errClear(errClear), .frameData(frameData2), .frameValid(frameValid2),
    .frameError(frameError2), .errCount(errCount2), .busy(busy2));

  // Pulse monitor; captured frames are compared to constants by the tests
  always @(negedge sysClk) begin
    if (frameValid) begin cap[vcnt % 8] = frameData; vcnt++; end
    if (frameError) ecnt++;
    if (frameValid2) vcnt2++;
    if (frameError2) ecnt2++;
  end

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spiSdi = val[i];
      repeat (3) @(negedge sysClk);
      spiClk = 1'b1;
      repeat (3) @(negedge sysClk);
      spiClk = 1'b0;
    end
    repeat (3) @(negedge sysClk);
  endtask

  task automatic do_frame(input logic [31:0] val, input int n);
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    shift_bits(val, n);
    spiLe = 1'b1;
    repeat (8) @(negedge sysClk);
  endtask

  task automatic test_reset;
    sysReset = 1'b1; spiLe = 1'b1; spiClk = 1'b0; spiSdi = 1'b0; errClear = 1'b0;
    repeat (3) @(negedge sysClk);
    n_cmp++; if (frameData !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", frameData); end
    n_cmp++; if (frameValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", frameValid); end
    n_cmp++; if (frameError !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", frameError); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL rst_errcount: got %0d want 0", errCount); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL rst_busy2: got %b want 0", busy2); end
    sysReset = 1'b0;
    repeat (6) @(negedge sysClk);
    // First synchronized LE high is a rise in IDLE and must do nothing
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_le_rise_busy: got %b want 0", busy); end
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL idle_le_rise_err: got %0d want 0", ecnt); end
  endtask

  task automatic test_valid_frame;
    vcnt = 0; ecnt = 0;
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_shift: got %b want 1", busy); end
    shift_bits(32'hA5, 8);
    spiLe = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge sysClk);
      n_cmp++;
      if (frameValid !== (i == 4)) begin
        n_bad++; $display("FAIL latency_valid[%0d]: got %b want %b", i, frameValid, (i == 4));
      end
    end
    n_cmp++; if (frameData !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %h want a5", frameData); end
    n_cmp++; if (vcnt !== 1) begin n_bad++; $display("FAIL a5_pulses: got %0d want 1", vcnt); end
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL a5_errpulses: got %0d want 0", ecnt); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL a5_errcount: got %0d want 0", errCount); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy: got %b want 0", busy); end
  endtask

  task automatic test_bad_frames;
    vcnt = 0; ecnt = 0;
    do_frame(32'h55, 7);
    do_frame(32'h155, 9);
    n_cmp++; if (ecnt !== 2) begin n_bad++; $display("FAIL bad_errpulses: got %0d want 2", ecnt); end
    n_cmp++; if (vcnt !== 0) begin n_bad++; $display("FAIL bad_validpulses: got %0d want 0", vcnt); end
    n_cmp++; if (errCount !== 16'd2) begin n_bad++; $display("FAIL bad_errcount: got %0d want 2", errCount); end
    n_cmp++; if (errCount2 !== 2'd2) begin n_bad++; $display("FAIL bad_errcount2: got %0d want 2", errCount2); end
    n_cmp++; if (frameData !== 8'hA5) begin n_bad++; $display("FAIL bad_data_held: got %h want a5", frameData); end
  endtask

  task automatic test_back_to_back;
    vcnt = 0; ecnt = 0;
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    shift_bits(32'h3C, 8);
    spiLe = 1'b1;
    @(negedge sysClk);
    spiLe = 1'b0;
    shift_bits(32'hC3, 8);
    spiLe = 1'b1;
    repeat (8) @(negedge sysClk);
    n_cmp++; if (vcnt !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", vcnt); end
    n_cmp++; if (cap[0] !== 8'h3C) begin n_bad++; $display("FAIL b2b_first: got %h want 3c", cap[0]); end
    n_cmp++; if (cap[1] !== 8'hC3) begin n_bad++; $display("FAIL b2b_second: got %h want c3", cap[1]); end
    n_cmp++; if (frameData !== 8'hC3) begin n_bad++; $display("FAIL b2b_data: got %h want c3", frameData); end
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d want 0", ecnt); end
  endtask

  task automatic test_reset_midframe;
    vcnt = 0; ecnt = 0;
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    shift_bits(32'hA, 4);
    sysReset = 1'b1;
    repeat (2) @(negedge sysClk);
    sysReset = 1'b0;
    repeat (8) @(negedge sysClk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (frameData !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %h want 00", frameData); end
    spiLe = 1'b1;
    repeat (4) @(negedge sysClk);
    do_frame(32'h81, 8);
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL mid_err: got %0d want 0", ecnt); end
    n_cmp++; if (vcnt !== 1) begin n_bad++; $display("FAIL mid_pulses: got %0d want 1", vcnt); end
    n_cmp++; if (cap[0] !== 8'h81) begin n_bad++; $display("FAIL mid_cap: got %h want 81", cap[0]); end
    n_cmp++; if (frameData2 !== 8'h81) begin n_bad++; $display("FAIL mid_data2: got %h want 81", frameData2); end
  endtask

  task automatic test_le_sclk_same;
    vcnt = 0; ecnt = 0;
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    shift_bits(32'h5A, 8);
    spiSdi = 1'b1; spiClk = 1'b1; spiLe = 1'b1;
    repeat (8) @(negedge sysClk);
    spiClk = 1'b0;
    repeat (4) @(negedge sysClk);
    n_cmp++; if (vcnt !== 1) begin n_bad++; $display("FAIL same_pulses: got %0d want 1", vcnt); end
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL same_err: got %0d want 0", ecnt); end
    n_cmp++; if (frameData !== 8'h5A) begin n_bad++; $display("FAIL same_data: got %h want 5a", frameData); end
  endtask

  task automatic test_saturation;
    sysReset = 1'b1;
    repeat (2) @(negedge sysClk);
    sysReset = 1'b0;
    repeat (4) @(negedge sysClk);
    ecnt = 0; vcnt2 = 0; ecnt2 = 0;
    for (int k = 0; k < 4; k++) do_frame(32'h55, 7);
    n_cmp++; if (errCount2 !== 2'd3) begin n_bad++; $display("FAIL sat_errcount2: got %0d want 3", errCount2); end
    n_cmp++; if (errCount !== 16'd4) begin n_bad++; $display("FAIL sat_errcount: got %0d want 4", errCount); end
    // Fifth bad frame with errClear landing on the error cycle
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
    shift_bits(32'h55, 7);
    spiLe = 1'b1;
    repeat (3) @(negedge sysClk);
    errClear = 1'b1;
    @(negedge sysClk);
    errClear = 1'b0;
    repeat (4) @(negedge sysClk);
    n_cmp++; if (errCount2 !== 2'd1) begin n_bad++; $display("FAIL clr_inc2: got %0d want 1", errCount2); end
    n_cmp++; if (errCount !== 16'd1) begin n_bad++; $display("FAIL clr_inc: got %0d want 1", errCount); end
    n_cmp++; if (ecnt2 !== 5) begin n_bad++; $display("FAIL sat_errpulses2: got %0d want 5", ecnt2); end
    n_cmp++; if (vcnt2 !== 0) begin n_bad++; $display("FAIL sat_validpulses2: got %0d want 0", vcnt2); end
    errClear = 1'b1;
    @(negedge sysClk);
    errClear = 1'b0;
    @(negedge sysClk);
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL clr_only: got %0d want 0", errCount); end
    n_cmp++; if (errCount2 !== 2'd0) begin n_bad++; $display("FAIL clr_only2: got %0d want 0", errCount2); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_frames();
    test_back_to_back();
    test_reset_midframe();
    test_le_sclk_same();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
